instruction_decoder: RTL and testbench

- Registered decoder for the 32-bit ACE instruction word.
- Splits the word into an opcode, two source operand descriptors and a destination register selector.
- Each source operand is either a 2-bit register selector or an 8-bit immediate.
- Sits between instruction fetch and the register file / ALU operand muxes; one-cycle latency.

---
 rtl/instruction_decoder.sv | 73 +++++++
 tb/tb_instruction_decoder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - registered field decoder for the 32-bit ACE instruction word
//
// Ports:
//   clk                        system clock, rising edge
//   rst_n                      asynchronous active-low reset
//   instruction_valid          instruction_data holds a word to decode this cycle
//   instruction_data[31:0]     raw instruction word
//   decode_valid               registered: fields below came from a word accepted last cycle
//   opcode[3:0]                operation code, word[31:28]
//   input_type_1               source 1 kind (0 register, 1 immediate), word[27]
//   input_register_selector_1  source 1 register index, word[26:25]
//   input_immediate_1[7:0]     source 1 immediate, word[26:19]
//   input_type_2               source 2 kind (0 register, 1 immediate), word[18]
//   input_register_selector_2  source 2 register index, word[17:16]
//   input_immediate_2[7:0]     source 2 immediate, word[17:10]
//   output_register_selector   destination register index, word[9:8]
//   reserved_error             word[7:0] of the last accepted word was non-zero

module instruction_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instruction_valid,
    input  logic [31:0] instruction_data,
    output logic        decode_valid,
    output logic [3:0]  opcode,
    output logic        input_type_1,
    output logic [1:0]  input_register_selector_1,
    output logic [7:0]  input_immediate_1,
    output logic        input_type_2,
    output logic [1:0]  input_register_selector_2,
    output logic [7:0]  input_immediate_2,
    output logic [1:0]  output_register_selector,
    output logic        reserved_error
);

    // decode_valid follows instruction_valid every cycle; the fields and
    // reserved_error only load on an accepted word so consumers can keep
    // reading the last decode while the fetch stream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decode_valid <= 1'b0;
        end else begin
            decode_valid <= instruction_valid;
        end
    end

    // Register selectors overlap the top bits of the immediate fields; both
    // views are always presented and the consumer picks one via input_type_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode                    <= 4'd0;
            input_type_1              <= 1'b0;
            input_register_selector_1 <= 2'd0;
            input_immediate_1         <= 8'd0;
            input_type_2              <= 1'b0;
            input_register_selector_2 <= 2'd0;
            input_immediate_2         <= 8'd0;
            output_register_selector  <= 2'd0;
            reserved_error            <= 1'b0;
        end else if (instruction_valid) begin
            opcode                    <= instruction_data[31:28];
            input_type_1              <= instruction_data[27];
            input_register_selector_1 <= instruction_data[26:25];
            input_immediate_1         <= instruction_data[26:19];
            input_type_2              <= instruction_data[18];
            input_register_selector_2 <= instruction_data[17:16];
            input_immediate_2         <= instruction_data[17:10];
            output_register_selector  <= instruction_data[9:8];
            reserved_error            <= |instruction_data[7:0];
        end
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// tb/tb_instruction_decoder.sv - self-checking bench for instruction_decoder

module tb_instruction_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instruction_valid;
    logic [31:0] instruction_data;
    logic        decode_valid;
    logic [3:0]  opcode;
    logic        input_type_1;
    logic [1:0]  input_register_selector_1;
    logic [7:0]  input_immediate_1;
    logic        input_type_2;
    logic [1:0]  input_register_selector_2;
    logic [7:0]  input_immediate_2;
    logic [1:0]  output_register_selector;
    logic        reserved_error;

    instruction_decoder dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .instruction_valid         (instruction_valid),
        .instruction_data          (instruction_data),
        .decode_valid              (decode_valid),
        .opcode                    (opcode),
        .input_type_1              (input_type_1),
        .input_register_selector_1 (input_register_selector_1),
        .input_immediate_1         (input_immediate_1),
        .input_type_2              (input_type_2),
        .input_register_selector_2 (input_register_selector_2),
        .input_immediate_2         (input_immediate_2),
        .output_register_selector  (output_register_selector),
        .reserved_error            (reserved_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: last accepted word plus the valid flag.
    bit          exp_dv;
    int unsigned exp_word;

    function automatic int unsigned field(input int unsigned w, input int lsb, input int width);
        return (w / (32'd1 << lsb)) % (32'd1 << width);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".decode_valid"}, 32'(decode_valid), 32'(exp_dv));
        chk({tag, ".opcode"}, 32'(opcode), field(exp_word, 28, 4));
        chk({tag, ".type1"}, 32'(input_type_1), field(exp_word, 27, 1));
        chk({tag, ".reg1"}, 32'(input_register_selector_1), field(exp_word, 25, 2));
        chk({tag, ".imm1"}, 32'(input_immediate_1), field(exp_word, 19, 8));
        chk({tag, ".type2"}, 32'(input_type_2), field(exp_word, 18, 1));
        chk({tag, ".reg2"}, 32'(input_register_selector_2), field(exp_word, 16, 2));
        chk({tag, ".imm2"}, 32'(input_immediate_2), field(exp_word, 10, 8));
        chk({tag, ".dest"}, 32'(output_register_selector), field(exp_word, 8, 2));
        chk({tag, ".rsv_err"}, 32'(reserved_error), 32'(field(exp_word, 0, 8) != 0));
    endtask

    // Drive one cycle of input, advance the model at the edge, check 1 time unit later.
    task automatic step(input bit v, input logic [31:0] d, input string tag);
        instruction_valid = v;
        instruction_data  = d;
        @(posedge clk);
        if (rst_n) begin
            exp_dv = v;
            if (v) exp_word = d;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        exp_dv   = 0;
        exp_word = 0;

        // Reset held with a valid all-ones word presented: nothing captured.
        rst_n             = 1'b0;
        instruction_valid = 1'b1;
        instruction_data  = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");

        // Release mid-cycle; the next edge captures the word still presented.
        #2 rst_n = 1'b1;
        step(1'b1, 32'hFFFF_FFFF, "first_after_reset");

        step(1'b1, 32'h0207_FC00, "w0207FC00");
        chk("w0207FC00.imm1_lit", 32'(input_immediate_1), 32'd64);
        chk("w0207FC00.reg1_lit", 32'(input_register_selector_1), 32'd1);
        chk("w0207FC00.imm2_lit", 32'(input_immediate_2), 32'd255);

        step(1'b1, 32'h1604_A900, "w1604A900");
        chk("w1604A900.imm2_lit", 32'(input_immediate_2), 32'd42);
        step(1'b1, 32'h2808_0200, "w28080200");
        chk("w28080200.dest_lit", 32'(output_register_selector), 32'd2);

        step(1'b1, 32'h3FFA_0300, "w3FFA0300");
        step(1'b0, 32'h1234_5678, "hold1");
        step(1'b0, 32'hFFFF_FFFF, "hold2");
        chk("hold2.opcode_lit", 32'(opcode), 32'd3);

        step(1'b1, 32'h0000_00A5, "w000000A5");
        chk("w000000A5.rsv_lit", 32'(reserved_error), 32'd1);
        step(1'b1, 32'h0000_0000, "w00000000");
        step(1'b0, 32'h0000_00FF, "rsv_hold");

        // Randomized stream, including bursts and reserved-clean words.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] d;
            d = $urandom;
            if ($urandom_range(0, 2) == 0) d[7:0] = 8'h00;
            step(($urandom_range(0, 3) != 0), d, "rand");
        end

        // Asynchronous reset between edges while decode_valid is high.
        step(1'b1, 32'hABCD_EF01, "pre_async");
        #2 rst_n = 1'b0;
        exp_dv   = 0;
        exp_word = 0;
        #1;
        check_all("async_reset");
        step(1'b1, 32'h5555_5555, "in_reset");
        #2 rst_n = 1'b1;
        step(1'b1, 32'h0207_FC00, "post_async");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
